// File: rtl/pipe_pkg.sv
// Shared constants for the EX-stage forwarding and load-use hazard logic.
// Forward-select encodings, stall FSM states and the default address width.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_WBSH  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

endpackage

// File: rtl/fwd_select.sv
// Priority operand-forwarding selector for one ALU source register.
// EX/MEM beats MEM/WB beats the write-back shadow; r0 never forwards.
module fwd_select
  import pipe_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic [AW-1:0] i_src,
  input  logic          i_exmem_en,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic          i_memwb_en,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic          i_wbsh_en,
  input  logic [AW-1:0] i_wbsh_rd,
  output logic [1:0]    o_sel
);

  logic w_hit_exmem;
  logic w_hit_memwb;
  logic w_hit_wbsh;

  assign w_hit_exmem = i_exmem_en && (i_exmem_rd != '0)
                       && (i_exmem_rd == i_src);
  assign w_hit_memwb = i_memwb_en && (i_memwb_rd != '0)
                       && (i_memwb_rd == i_src);
  assign w_hit_wbsh  = i_wbsh_en && (i_wbsh_rd == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (i_src != '0) begin
      if (w_hit_exmem)      o_sel = FWD_EXMEM;
      else if (w_hit_memwb) o_sel = FWD_MEMWB;
      else if (w_hit_wbsh)  o_sel = FWD_WBSH;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding plus multi-cycle load-use stall control beside ID/EX.
// A registered WB shadow covers same-cycle regfile write/read without bypass.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rs,
  input  logic              ifid_use_rt,
  input  logic [REG_AW-1:0] idex_rs,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic              idex_memread,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);
  localparam bit         MULTI  = (LOAD_LAT > 1);

  state_e            r_state;
  logic [3:0]        r_rem;
  logic              r_sh_v;
  logic [REG_AW-1:0] r_sh_rd;
  logic [CNT_W-1:0]  r_cnt;

  state_e            w_state_nxt;
  logic [3:0]        w_rem_nxt;
  logic              w_stall;
  logic              w_hazard;
  logic              w_rs_hit;
  logic              w_rt_hit;

  fwd_select #(.AW(REG_AW)) u_fwd_a (
    .i_src      (idex_rs),
    .i_exmem_en (exmem_regwrite),
    .i_exmem_rd (exmem_rd),
    .i_memwb_en (memwb_regwrite),
    .i_memwb_rd (memwb_rd),
    .i_wbsh_en  (r_sh_v),
    .i_wbsh_rd  (r_sh_rd),
    .o_sel      (forward_a)
  );

  fwd_select #(.AW(REG_AW)) u_fwd_b (
    .i_src      (idex_rt),
    .i_exmem_en (exmem_regwrite),
    .i_exmem_rd (exmem_rd),
    .i_memwb_en (memwb_regwrite),
    .i_memwb_rd (memwb_rd),
    .i_wbsh_en  (r_sh_v),
    .i_wbsh_rd  (r_sh_rd),
    .o_sel      (forward_b)
  );

  assign w_rs_hit = ifid_use_rs && (ifid_rs == idex_rd);
  assign w_rt_hit = ifid_use_rt && (ifid_rt == idex_rd);
  assign w_hazard = idex_memread && (idex_rd != '0)
                    && (w_rs_hit || w_rt_hit);

  // Detect cycle counts as the first stall; STALL covers the rest.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_stall     = 1'b0;
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_rem_nxt   = 4'd0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_stall = w_hazard;
          if (w_hazard && MULTI) begin
            w_state_nxt = ST_STALL;
            w_rem_nxt   = LAT_M1;
          end
        end
        ST_STALL: begin
          w_stall   = 1'b1;
          w_rem_nxt = r_rem - 4'd1;
          if (r_rem == 4'd1) w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= 4'd0;
      r_sh_v  <= 1'b0;
      r_sh_rd <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_sh_v  <= memwb_regwrite && (memwb_rd != '0);
      r_sh_rd <= memwb_rd;
      if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall        = w_stall;
  assign idex_bubble  = w_stall;
  assign stall_cycles = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomised and directed checks of fwd_hazard_unit against a cycle model.
// Three instances: LOAD_LAT=1, LOAD_LAT=3, and LOAD_LAT=3 with a 2-bit counter.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n, flush;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd;
  logic [4:0] exmem_rd, memwb_rd;
  logic       ifid_use_rs, ifid_use_rt, idex_memread;
  logic       exmem_regwrite, memwb_regwrite;

  logic [1:0]  fa1, fb1, fa3, fb3, fas, fbs;
  logic        st1, bb1, st3, bb3, sts, bbs;
  logic [15:0] sc1, sc3;
  logic [1:0]  scs;

  int errors = 0;
  int checks = 0;

  int         left1, left3, cnt1, cnt3, cnts;
  bit         sh_v;
  logic [4:0] sh_rd;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.LOAD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .forward_a(fa1), .forward_b(fb1), .stall(st1),
    .idex_bubble(bb1), .stall_cycles(sc1));

  fwd_hazard_unit #(.LOAD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .forward_a(fa3), .forward_b(fb3), .stall(st3),
    .idex_bubble(bb3), .stall_cycles(sc3));

  fwd_hazard_unit #(.LOAD_LAT(3), .CNT_W(2)) us (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_use_rs(ifid_use_rs), .ifid_use_rt(ifid_use_rt),
    .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_memread(idex_memread),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .forward_a(fas), .forward_b(fbs), .stall(sts),
    .idex_bubble(bbs), .stall_cycles(scs));

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return 2'b10;
    if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return 2'b01;
    if (sh_v && sh_rd == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit hazard();
    return idex_memread && idex_rd != 0 &&
           ((ifid_use_rs && ifid_rs == idex_rd) ||
            (ifid_use_rt && ifid_rt == idex_rd));
  endfunction

  // Stall cycles still owed for the current load: detect cycle included.
  function automatic bit exp_stall(input int left);
    if (flush) return 1'b0;
    if (left > 0) return 1'b1;
    return hazard();
  endfunction

  function automatic int next_left(input int left, input int lat);
    if (flush) return 0;
    if (left > 0) return left - 1;
    if (hazard()) return lat - 1;
    return 0;
  endfunction

  task automatic tick();
    bit s1, s3;
    s1 = exp_stall(left1);
    s3 = exp_stall(left3);
    @(posedge clk);
    if (!rst_n) begin
      left1 = 0; left3 = 0;
      cnt1 = 0; cnt3 = 0; cnts = 0;
      sh_v = 0; sh_rd = 0;
    end else begin
      if (s1 && cnt1 < 65535) cnt1++;
      if (s3 && cnt3 < 65535) cnt3++;
      if (s3 && cnts < 3) cnts++;
      left1 = next_left(left1, 1);
      left3 = next_left(left3, 3);
      sh_v  = memwb_regwrite && memwb_rd != 0;
      sh_rd = memwb_rd;
    end
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0;
    ifid_rs = 0; ifid_rt = 0; ifid_use_rs = 0; ifid_use_rt = 0;
    idex_rs = 0; idex_rt = 0; idex_rd = 0; idex_memread = 0;
    exmem_regwrite = 0; exmem_rd = 0;
    memwb_regwrite = 0; memwb_rd = 0;
  endtask

  task automatic set_hazard();
    idex_memread = 1; idex_rd = 5'd3;
    ifid_use_rt = 1; ifid_rt = 5'd3;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1;
    #2;
    checks++;
    if ({fa1, fb1, fa3, fb3} !== 8'h00) begin
      errors++;
      $display("FAIL reset_fwd: got %h expected 00", {fa1, fb1, fa3, fb3});
    end
    checks++;
    if ({st1, bb1, st3, bb3, sts, bbs} !== 6'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b expected 000000",
               {st1, bb1, st3, bb3, sts, bbs});
    end
    checks++;
    if ({sc1, sc3, scs} !== 34'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d expected 0", sc1, sc3, scs);
    end
  endtask

  task automatic test_priority();
    clear_inputs();
    tick();
    exmem_regwrite = 1; exmem_rd = 5'd8;
    memwb_regwrite = 1; memwb_rd = 5'd8;
    idex_rs = 5'd8; idex_rt = 5'd9;
    #2;
    checks++;
    if (fa1 !== 2'b10) begin
      errors++;
      $display("FAIL prio_exmem: got %b expected 10", fa1);
    end
    checks++;
    if (fb1 !== 2'b00) begin
      errors++;
      $display("FAIL prio_nomatch: got %b expected 00", fb1);
    end
    exmem_regwrite = 0;
    #2;
    checks++;
    if (fa3 !== 2'b01) begin
      errors++;
      $display("FAIL prio_memwb: got %b expected 01", fa3);
    end
    tick();
    memwb_regwrite = 0;
    #2;
    checks++;
    if (fa1 !== 2'b11) begin
      errors++;
      $display("FAIL prio_shadow: got %b expected 11", fa1);
    end
  endtask

  task automatic test_shadow();
    clear_inputs();
    tick();
    memwb_regwrite = 1; memwb_rd = 5'd5;
    tick();
    memwb_regwrite = 0;
    idex_rt = 5'd5;
    #2;
    checks++;
    if (fb1 !== 2'b11) begin
      errors++;
      $display("FAIL shadow_hit: got %b expected 11", fb1);
    end
    memwb_regwrite = 1; memwb_rd = 5'd0;
    tick();
    memwb_regwrite = 0;
    #2;
    checks++;
    if (fb1 !== 2'b00) begin
      errors++;
      $display("FAIL shadow_r0: got %b expected 00", fb1);
    end
  endtask

  task automatic test_load_lat();
    int c1, c3;
    clear_inputs();
    tick();
    c1 = cnt1; c3 = cnt3;
    set_hazard();
    #2;
    checks++;
    if ({st1, bb1, st3, bb3} !== 4'b1111) begin
      errors++;
      $display("FAIL detect: got %b expected 1111", {st1, bb1, st3, bb3});
    end
    tick();
    idex_memread = 0;
    #2;
    checks++;
    if (st1 !== 1'b0 || sc1 !== 16'(c1 + 1)) begin
      errors++;
      $display("FAIL lat1_end: got stall=%b cnt=%0d expected 0/%0d",
               st1, sc1, c1 + 1);
    end
    checks++;
    if ({st3, bb3} !== 2'b11) begin
      errors++;
      $display("FAIL lat3_n1: got %b expected 11", {st3, bb3});
    end
    tick();
    #2;
    checks++;
    if (st3 !== 1'b1) begin
      errors++;
      $display("FAIL lat3_n2: got %b expected 1", st3);
    end
    tick();
    #2;
    checks++;
    if (st3 !== 1'b0 || sc3 !== 16'(c3 + 3)) begin
      errors++;
      $display("FAIL lat3_end: got stall=%b cnt=%0d expected 0/%0d",
               st3, sc3, c3 + 3);
    end
    checks++;
    if (scs !== 2'd3) begin
      errors++;
      $display("FAIL cnt_sat: got %0d expected 3", scs);
    end
  endtask

  task automatic test_flush();
    int c3;
    clear_inputs();
    tick();
    c3 = cnt3;
    set_hazard();
    tick();
    idex_memread = 0;
    flush = 1;
    #2;
    checks++;
    if ({st3, bb3} !== 2'b00) begin
      errors++;
      $display("FAIL flush_cut: got %b expected 00", {st3, bb3});
    end
    tick();
    flush = 0;
    #2;
    checks++;
    if (st3 !== 1'b0 || sc3 !== 16'(c3 + 1)) begin
      errors++;
      $display("FAIL flush_idle: got stall=%b cnt=%0d expected 0/%0d",
               st3, sc3, c3 + 1);
    end
    set_hazard();
    flush = 1;
    tick();
    flush = 0;
    idex_memread = 0;
    #2;
    checks++;
    if (st3 !== 1'b0) begin
      errors++;
      $display("FAIL flush_detect: got %b expected 0", st3);
    end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    tick();
    idex_memread = 1; idex_rd = 0;
    ifid_use_rs = 1; ifid_rs = 0;
    exmem_regwrite = 1; exmem_rd = 0;
    idex_rs = 0;
    #2;
    checks++;
    if ({st1, st3, fa1} !== 4'b0000) begin
      errors++;
      $display("FAIL zero_reg: got %b expected 0000", {st1, st3, fa1});
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    tick();
    set_hazard();
    tick();
    idex_memread = 0;
    #2;
    checks++;
    if (st3 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got %b expected 1", st3);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    #2;
    checks++;
    if (st3 !== 1'b0 || sc3 !== 16'd0 || sc1 !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got stall=%b cnt=%0d/%0d expected 0/0/0",
               st3, sc3, sc1);
    end
  endtask

  task automatic test_random();
    logic [1:0] ea, eb;
    bit         e1, e3;
    for (int i = 0; i < 400; i++) begin
      flush          = ($urandom_range(0, 7) == 0);
      ifid_rs        = 5'($urandom_range(0, 3));
      ifid_rt        = 5'($urandom_range(0, 3));
      ifid_use_rs    = 1'($urandom);
      ifid_use_rt    = 1'($urandom);
      idex_rs        = 5'($urandom_range(0, 3));
      idex_rt        = 5'($urandom_range(0, 3));
      idex_rd        = 5'($urandom_range(0, 3));
      idex_memread   = 1'($urandom);
      exmem_regwrite = 1'($urandom);
      exmem_rd       = 5'($urandom_range(0, 3));
      memwb_regwrite = 1'($urandom);
      memwb_rd       = 5'($urandom_range(0, 3));
      #2;
      ea = exp_fwd(idex_rs);
      eb = exp_fwd(idex_rt);
      e1 = exp_stall(left1);
      e3 = exp_stall(left3);
      checks++;
      if ({fa1, fb1, fa3, fb3, fas, fbs} !== {ea, eb, ea, eb, ea, eb}) begin
        errors++;
        $display("FAIL rnd_fwd[%0d]: got %h expected %h", i,
                 {fa1, fb1, fa3, fb3, fas, fbs}, {ea, eb, ea, eb, ea, eb});
      end
      checks++;
      if ({st1, bb1, st3, bb3, sts, bbs} !== {e1, e1, e3, e3, e3, e3}) begin
        errors++;
        $display("FAIL rnd_stall[%0d]: got %b expected %b", i,
                 {st1, bb1, st3, bb3, sts, bbs}, {e1, e1, e3, e3, e3, e3});
      end
      checks++;
      if ({sc1, sc3, scs} !== {16'(cnt1), 16'(cnt3), 2'(cnts)}) begin
        errors++;
        $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 i, sc1, sc3, scs, cnt1, cnt3, cnts);
      end
      tick();
    end
  endtask

  initial begin
    left1 = 0; left3 = 0;
    cnt1 = 0; cnt3 = 0; cnts = 0;
    sh_v = 0; sh_rd = 0;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_priority();
    test_shadow();
    test_load_lat();
    test_flush();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding unit.
- Combines operand forwarding with load-use hazard detection for the 5-stage pipeline. Adds a third forwarding source from a registered write-back shadow, and a multi-cycle load-use stall FSM sized by memory latency.
- Sits beside ID/EX: drives the ALU operand muxes, PC/IF-ID write enables and the ID/EX bubble insert.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- LOAD_LAT, 1, total stall cycles per load-use hazard; legal range 1..15.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  branch/exception flush; aborts any stall in progress.
- ifid_rs  input  REG_AW  rs of the instruction in ID.
- ifid_rt  input  REG_AW  rt of the instruction in ID.
- ifid_use_rs  input  1  ID instruction reads rs.
- ifid_use_rt  input  1  ID instruction reads rt.
- idex_rs  input  REG_AW  rs of the instruction in EX.
- idex_rt  input  REG_AW  rt of the instruction in EX.
- idex_rd  input  REG_AW  destination of the instruction in EX.
- idex_memread  input  1  instruction in EX is a load.
- exmem_regwrite  input  1  EX/MEM writes a register.
- exmem_rd  input  REG_AW  EX/MEM destination.
- memwb_regwrite  input  1  MEM/WB writes a register.
- memwb_rd  input  REG_AW  MEM/WB destination.
- forward_a  output  2  ALU A select: 00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB shadow.
- forward_b  output  2  ALU B select, same encoding.
- stall  output  1  hold PC and IF/ID.
- idex_bubble  output  1  zero ID/EX control fields this cycle.
- stall_cycles  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, remaining=0.
  - WB shadow valid=0, shadow rd=0.
  - stall_cycles=0.
  - Combinational outputs follow from reset state: forward_a/b=00 unless inputs match, stall=0, idex_bubble=0 when no hazard.
- WB shadow: every cycle, shadow_valid <= memwb_regwrite and (memwb_rd != 0); shadow_rd <= memwb_rd. It represents the write retired on the previous cycle and covers regfile write/read in the same cycle without write-through.
- Forwarding (combinational, independent for A/rs and B/rt). Priority, first match wins:
  - EX/MEM: exmem_regwrite, exmem_rd != 0, exmem_rd == src -> 10.
  - MEM/WB: memwb_regwrite, memwb_rd != 0, memwb_rd == src -> 01.
  - Shadow: shadow_valid, shadow_rd == src -> 11.
  - Otherwise -> 00.
  - src 0 never forwards.
- Hazard detect (combinational):
  - Condition: idex_memread, idex_rd != 0, and ((ifid_use_rs and ifid_rs == idex_rd) or (ifid_use_rt and ifid_rt == idex_rd)).
- FSM states:
  - IDLE:
    - stall = idex_bubble = hazard.
    - If hazard, not flush, and LOAD_LAT > 1: go to STALL with remaining = LOAD_LAT-1.
    - Otherwise stay in IDLE.
  - STALL:
    - stall = idex_bubble = 1.
    - Detection is ignored, because EX holds a bubble.
    - remaining decrements each cycle. On the cycle remaining == 1, the next state is IDLE.
- Total stall cycles per hazard = LOAD_LAT, exactly.
- LOAD_LAT=1 gives the classic single-cycle stall; STALL is never entered.
- flush:
  - In any state, flush=1 forces stall=0 and idex_bubble=0 that cycle.
  - Next state is IDLE with remaining=0. A flush in the detect cycle prevents entry into STALL.
- stall_cycles increments on every cycle stall=1, and saturates at all-ones.
- Reset mid-stall returns to IDLE on that edge; there is no residual stall.
- Widths: remaining is 4 bits; all comparisons are REG_AW bits, unsigned.

Decomposition:
- Shared package pipe_pkg:
  - Forward-select constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01, FWD_WBSH=2'b11.
  - State encoding ST_IDLE / ST_STALL.
  - Default REG_AW.
- Sub-module fwd_select: the combinational priority selector, instantiated twice (rs, rt). Inputs: src, the three sources and their enables; output: 2-bit select.

Test Plan:
- exmem_regwrite=1, exmem_rd=8, memwb_regwrite=1, memwb_rd=8, idex_rs=8 -> forward_a=10 (EX/MEM priority); idex_rt=9 -> forward_b=00.
- Cycle N: memwb_regwrite=1, memwb_rd=5. Cycle N+1: memwb_regwrite=0, exmem_regwrite=0, idex_rt=5 -> forward_b=11. With memwb_rd=0 at cycle N instead -> forward_b=00.
- LOAD_LAT=1: idex_memread=1, idex_rd=3, ifid_use_rt=1, ifid_rt=3 -> stall=idex_bubble=1 for exactly 1 cycle; stall_cycles 0->1.
- LOAD_LAT=3, same hazard -> stall=1 for cycles N, N+1, N+2 and 0 at N+3; stall_cycles=3.
- LOAD_LAT=3, flush=1 at cycle N+1 -> stall=0 at N+1, state IDLE at N+2, stall_cycles=1.
- Edge cases:
  - idex_rd=0 with a matching ifid_rs=0 -> no stall.
  - rst_n=0 during STALL -> stall=0 next cycle and stall_cycles=0.
